// File: rtl/alu16_core_if.sv
// alu16_core_if: operand/select request and registered result/flags bundle for alu16_core.
interface alu16_core_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel0;
    logic             sel1;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    modport master (
        output a, b, sel0, sel1, in_valid,
        input  out, out_valid, zero, carry, negative, overflow
    );
    modport slave (
        input  a, b, sel0, sel1, in_valid,
        output out, out_valid, zero, carry, negative, overflow
    );
endinterface

// File: rtl/alu16_core.sv
// alu16_core: 2-bit-opcode ADD/SUB/AND/OR ALU with a one-cycle registered result and valid strobe.
// Status flags are built only when ALU16_FLAGS_EN is defined; otherwise they are tied to 0.
module alu16_core #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu16_core_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    assign w_op = {bus.sel1, bus.sel0};
`ifdef ALU16_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_carry;
    logic           w_ovf;
    logic           r_zero;
    logic           r_carry;
    logic           r_negative;
    logic           r_overflow;
    // Top bit of the zero-extended difference is the unsigned borrow (a < b).
    always_comb begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
        w_res   = w_op == 2'b00 ? w_sum[MSB:0] :
                  w_op == 2'b01 ? w_diff[MSB:0] :
                  w_op == 2'b10 ? (bus.a & bus.b) : (bus.a | bus.b);
        w_carry = w_op[1] ? 1'b0 : (w_op[0] ? w_diff[WIDTH] : w_sum[WIDTH]);
        w_ovf   = w_op[1] ? 1'b0 :
                  w_op[0] ? (bus.a[MSB] != bus.b[MSB]) && (w_res[MSB] != bus.a[MSB]) :
                            (bus.a[MSB] == bus.b[MSB]) && (w_res[MSB] != bus.a[MSB]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.in_valid) begin
            r_zero     <= w_res == '0;
            r_carry    <= w_carry;
            r_negative <= w_res[MSB];
            r_overflow <= w_ovf;
        end
    end
    assign bus.zero     = r_zero;
    assign bus.carry    = r_carry;
    assign bus.negative = r_negative;
    assign bus.overflow = r_overflow;
`else
    assign w_res = w_op == 2'b00 ? bus.a + bus.b :
                   w_op == 2'b01 ? bus.a - bus.b :
                   w_op == 2'b10 ? (bus.a & bus.b) : (bus.a | bus.b);
    assign bus.zero     = 1'b0;
    assign bus.carry    = 1'b0;
    assign bus.negative = 1'b0;
    assign bus.overflow = 1'b0;
`endif
    // Result holds across idle cycles; only the strobe follows in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) r_out <= w_res;
        end
    end
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_alu16_core.sv
// tb_alu16_core: directed-vector self-checking bench for alu16_core.
module tb_alu16_core;
`ifdef ALU16_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    alu16_core_if #(.WIDTH(16)) bus ();
    alu16_core #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] flags();
        return {bus.zero, bus.carry, bus.negative, bus.overflow};
    endfunction
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel, input logic v);
        bus.a        = a;
        bus.b        = b;
        {bus.sel1, bus.sel0} = sel;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask
    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] sel, input logic [15:0] e_out, input logic [3:0] e_f);
        drive(a, b, sel, 1'b1);
        chk({tag, "_out"}, 32'(bus.out), 32'(e_out));
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_flg"}, 32'(flags()), 32'(FL ? e_f : 4'b0000));
    endtask
    initial begin
        bus.a = '0; bus.b = '0; bus.sel0 = 1'b0; bus.sel1 = 1'b0; bus.in_valid = 1'b1;
        #3;
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_flg", 32'(flags()), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_vld", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        // flags packed {zero, carry, negative, overflow}
        op("add",     16'd20,   16'd38,   2'b00, 16'd58,   4'b0000);
        op("sub",     16'd8,    16'd5,    2'b01, 16'd3,    4'b0000);
        op("and",     16'd5,    16'd4,    2'b10, 16'd4,    4'b0000);
        op("or",      16'd6,    16'd3,    2'b11, 16'd7,    4'b0000);
        op("add_wrap",16'hFFFF, 16'h0001, 2'b00, 16'h0000, 4'b1100);
        op("add_ovf", 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 4'b0011);
        op("sub_brw", 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 4'b0110);
        op("sub_ovf", 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 4'b0001);
        op("and_flg", 16'hF0F0, 16'h0F0F, 2'b10, 16'h0000, 4'b1000);
        drive(16'h1234, 16'h1111, 2'b01, 1'b0);
        chk("idle_vld", 32'(bus.out_valid), 32'd0);
        chk("idle_out", 32'(bus.out), 32'd0);
        chk("idle_flg", 32'(flags()), 32'(FL ? 4'b1000 : 4'b0000));
        op("s0", 16'd20, 16'd38, 2'b00, 16'd58, 4'b0000);
        op("s1", 16'd8,  16'd5,  2'b01, 16'd3,  4'b0000);
        op("s2", 16'd5,  16'd4,  2'b10, 16'd4,  4'b0000);
        op("s3", 16'd6,  16'd3,  2'b11, 16'd7,  4'b0000);
        drive(16'hFFFF, 16'h0001, 2'b00, 1'b0);
        chk("hold_vld", 32'(bus.out_valid), 32'd0);
        chk("hold_out", 32'(bus.out), 32'd7);
        drive(16'hFFFF, 16'hFFFF, 2'b11, 1'b0);
        chk("hold2_out", 32'(bus.out), 32'd7);
        op("pre_rst", 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 4'b0110);
        bus.a = 16'h7FFF; bus.b = 16'h0001; {bus.sel1, bus.sel0} = 2'b00; bus.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(bus.out), 32'd0);
        chk("arst_vld", 32'(bus.out_valid), 32'd0);
        chk("arst_flg", 32'(flags()), 32'd0);
        @(posedge clk); #1;
        chk("arst_edge_out", 32'(bus.out), 32'd0);
        chk("arst_edge_vld", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        op("post_rst", 16'd1, 16'd1, 2'b00, 16'd2, 4'b0000);
        drive(16'd0, 16'd0, 2'b00, 1'b0);
        chk("post_idle_vld", 32'(bus.out_valid), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
